instruction_dispatcher: RTL and testbench
=========================================

// Module: instruction_dispatcher
// PURPOSE
//  Consumer end of the instruction queue: pops instructions (iq_read_o), waits the queue's 1-cycle read latency,
//  decodes, and presents one command per instruction to the TPU control path over a valid/ready handshake.
//  Handles NOP/HALT locally, flags illegal opcodes, counts retired instructions. Sits between queue and sequencer.
// PARAMETERS
//  INSTR_SIZE  32  instruction width (package constant; format below is fixed for 32)
//  CNT_W       16  width of retired-instruction counter
// PORTS
//  clk_i          in   1           clock; all logic on posedge
//  rst_ni         in   1           asynchronous, active-low reset
//  start_i        in   1           leave HALTED (1-cycle pulse; ignored in other states)
//  iq_empty_i     in   1           queue holds no instruction
//  iq_instr_i     in   INSTR_SIZE  queue data; valid the cycle after iq_read_o=1
//  iq_read_o      out  1           pop request, max one cycle per pop
//  cmd_valid_o    out  1           command valid
//  cmd_ready_i    in   1           sequencer accepts command
//  cmd_opcode_o   out  4           opcode_e
//  cmd_ub_addr_o  out  12          unified-buffer address
//  cmd_acc_addr_o out  12          accumulator address
//  cmd_len_o      out  4           length-1 (rows/tiles)
//  halted_o       out  1           FSM in HALTED
//  err_o          out  1           sticky: illegal opcode seen
//  retired_o      out  CNT_W       instructions consumed (issued+NOP+HALT), wraps
// BEHAVIOUR
//  Format: [31:28] opcode, [27:16] ub_addr, [15:4] acc_addr, [3:0] len.
//  Opcodes: 0 NOP, 1 RD_HOST, 2 RD_WEIGHT, 3 MATMUL, 4 ACTIVATE, 5 WR_HOST, 15 HALT; 6-14 illegal.
//  Reset: state=HALTED, halted_o=1, all other outputs 0 (cmd fields 0, retired_o 0, err_o 0).
//  FSM: HALTED -start_i-> FETCH. FETCH: if !iq_empty_i assert iq_read_o (combinational, this cycle) -> WAIT, else stay.
//   WAIT: register decoded iq_instr_i into cmd_* at cycle end -> ISSUE (legal issuable op), FETCH (NOP/illegal),
//   HALTED (HALT; halted_o=1 next cycle). NOP/HALT/illegal never raise cmd_valid_o.
//  ISSUE: cmd_valid_o=1, cmd_* stable until cmd_valid_o&&cmd_ready_i; then cmd_valid_o=0 next cycle -> FETCH.
//  Min latency: read cycle N, cmd_valid_o from N+2. Throughput 1 instr / 3 cycles with cmd_ready_i=1.
//  retired_o += 1 on issue handshake, or in WAIT for NOP/HALT/illegal; wraps 2^CNT_W-1 -> 0.
//  err_o set in WAIT on illegal opcode, cleared only by reset; instruction dropped, fetching continues.
//  iq_empty_i rising while in WAIT: no effect (data already popped). start_i outside HALTED: ignored.
//  Reset mid-operation: returns to reset state; an instruction popped but not issued is lost.
//  Never assert iq_read_o in WAIT, ISSUE (without prefetch), or HALTED.
// CONFIGURATION
//  `INSTR_PREFETCH_EN defined: in ISSUE, on handshake cycle with !iq_empty_i, iq_read_o=1 and FSM -> WAIT
//   directly (skips FETCH); throughput 1 instr / 2 cycles. Prefetch is suppressed only by iq_empty_i.
//  Undefined: behaviour exactly as above; iq_read_o only in FETCH.
// STRUCTURE
//  tpu_package: INSTR_SIZE, opcode_e enum, instr_t packed struct (fields above), field-width localparams,
//   dispatch_state_e (HALTED, FETCH, WAIT, ISSUE).
//  Sub-module instr_decode: combinational instr_t unpack + is_legal/is_issuable/is_halt/is_nop flags.
//  Top: FSM, cmd register, counter, sticky error.
// TESTING
//  1 Reset, start_i pulse, queue holds MATMUL 0x3_0A0_0B0_7, ready=1 -> read@N, cmd_valid@N+2 fields 3/0x0A0/0x0B0/7, retired=1.
//  2 cmd_ready_i low 5 cycles in ISSUE -> cmd_valid_o and fields stable all 5, no iq_read_o; single handshake.
//  3 Stream NOP, opcode 9, RD_HOST -> no cmd for first two, err_o=1 stays, RD_HOST issued, retired=3.
//  4 HALT then MATMUL queued -> halted_o=1, no read until start_i; after start_i MATMUL issued.
//  5 iq_empty_i=1 in FETCH 10 cycles -> iq_read_o=0; assert rst_ni low during ISSUE -> all outputs to reset values.
//  6 With `INSTR_PREFETCH_EN, 4 RD_WEIGHT back-to-back, ready=1 -> cmd_valid pulses every 2 cycles; without, every 3.

Source files
------------

// File: rtl/instruction_dispatcher_pkg.sv
// ============================================================================
//  Package     : tpu_package
//  Description : Shared types and constants for the instruction dispatcher:
//                instruction format, opcode encoding and dispatcher states.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tpu_package;

    // Instruction word layout: [31:28] opcode, [27:16] ub_addr,
    // [15:4] acc_addr, [3:0] len (length-1).
    localparam int INSTR_SIZE = 32;
    localparam int OPCODE_W   = 4;
    localparam int ADDR_W     = 12;
    localparam int LEN_W      = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP       = 4'd0,
        OP_RD_HOST   = 4'd1,
        OP_RD_WEIGHT = 4'd2,
        OP_MATMUL    = 4'd3,
        OP_ACTIVATE  = 4'd4,
        OP_WR_HOST   = 4'd5,
        OP_HALT      = 4'd15
    } opcode_e;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [ADDR_W-1:0]   ub_addr;
        logic [ADDR_W-1:0]   acc_addr;
        logic [LEN_W-1:0]    len;
    } instr_t;

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_FETCH  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ISSUE  = 2'd3
    } dispatch_state_e;

    // Opcodes that produce a command towards the sequencer.
    function automatic logic op_is_issuable(input logic [OPCODE_W-1:0] op);
        return (op >= OP_RD_HOST) && (op <= OP_WR_HOST);
    endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_dispatcher_decode.sv
// ============================================================================
//  Module      : instr_decode
//  Description : Combinational unpack of a raw instruction word into its
//                fields plus classification flags.
//  Ports       : instr_i        raw instruction word
//                opcode_o       opcode field
//                ub_addr_o      unified-buffer address field
//                acc_addr_o     accumulator address field
//                len_o          length-1 field
//                is_legal_o     opcode is one of the defined encodings
//                is_issuable_o  opcode produces a sequencer command
//                is_halt_o      HALT opcode
//                is_nop_o       NOP opcode
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_decode
    import tpu_package::*;
(
    input  logic [INSTR_SIZE-1:0] instr_i,
    output logic [OPCODE_W-1:0]   opcode_o,
    output logic [ADDR_W-1:0]     ub_addr_o,
    output logic [ADDR_W-1:0]     acc_addr_o,
    output logic [LEN_W-1:0]      len_o,
    output logic                  is_legal_o,
    output logic                  is_issuable_o,
    output logic                  is_halt_o,
    output logic                  is_nop_o
);

    instr_t w_instr;

    assign w_instr       = instr_t'(instr_i);
    assign opcode_o      = w_instr.opcode;
    assign ub_addr_o     = w_instr.ub_addr;
    assign acc_addr_o    = w_instr.acc_addr;
    assign len_o         = w_instr.len;

    assign is_nop_o      = (w_instr.opcode == OP_NOP);
    assign is_halt_o     = (w_instr.opcode == OP_HALT);
    assign is_issuable_o = op_is_issuable(w_instr.opcode);
    assign is_legal_o    = is_nop_o | is_halt_o | is_issuable_o;

endmodule

`default_nettype wire

// File: rtl/instruction_dispatcher.sv
// ============================================================================
//  Module      : instruction_dispatcher
//  Description : Consumer end of the instruction queue. Pops one instruction,
//                waits the queue's one-cycle read latency, decodes it and
//                presents a command to the sequencer over valid/ready.
//                NOP/HALT are handled locally, illegal opcodes set a sticky
//                error, and every consumed instruction is counted.
//  Config      : `INSTR_PREFETCH_EN - pop the next instruction on the command
//                handshake cycle (1 instr / 2 cycles instead of 1 / 3).
//  Ports       : clk_i, rst_ni             clock, async active-low reset
//                start_i                   leave HALTED (pulse)
//                iq_empty_i, iq_instr_i    queue status and read data
//                iq_read_o                 queue pop request
//                cmd_valid_o, cmd_ready_i  command handshake
//                cmd_opcode_o, cmd_ub_addr_o, cmd_acc_addr_o, cmd_len_o
//                                          command fields
//                halted_o                  dispatcher is halted
//                err_o                     sticky illegal-opcode flag
//                retired_o                 consumed-instruction counter
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_dispatcher
    import tpu_package::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  iq_empty_i,
    input  logic [INSTR_SIZE-1:0] iq_instr_i,
    output logic                  iq_read_o,
    output logic                  cmd_valid_o,
    input  logic                  cmd_ready_i,
    output logic [OPCODE_W-1:0]   cmd_opcode_o,
    output logic [ADDR_W-1:0]     cmd_ub_addr_o,
    output logic [ADDR_W-1:0]     cmd_acc_addr_o,
    output logic [LEN_W-1:0]      cmd_len_o,
    output logic                  halted_o,
    output logic                  err_o,
    output logic [CNT_W-1:0]      retired_o
);

    dispatch_state_e     state_q,    state_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic [OPCODE_W-1:0] opcode_q,   opcode_d;
    logic [ADDR_W-1:0]   ub_addr_q,  ub_addr_d;
    logic [ADDR_W-1:0]   acc_addr_q, acc_addr_d;
    logic [LEN_W-1:0]    len_q,      len_d;
    logic                halted_q,   halted_d;
    logic                err_q,      err_d;
    logic [CNT_W-1:0]    retired_q,  retired_d;
    logic                iq_read;

    logic [OPCODE_W-1:0] w_dec_opcode;
    logic [ADDR_W-1:0]   w_dec_ub_addr;
    logic [ADDR_W-1:0]   w_dec_acc_addr;
    logic [LEN_W-1:0]    w_dec_len;
    logic                w_is_legal;
    logic                w_is_issuable;
    logic                w_is_halt;
    logic                w_is_nop;
    logic                w_retire_local;

    instr_decode u_decode (
        .instr_i       (iq_instr_i),
        .opcode_o      (w_dec_opcode),
        .ub_addr_o     (w_dec_ub_addr),
        .acc_addr_o    (w_dec_acc_addr),
        .len_o         (w_dec_len),
        .is_legal_o    (w_is_legal),
        .is_issuable_o (w_is_issuable),
        .is_halt_o     (w_is_halt),
        .is_nop_o      (w_is_nop)
    );

    // Instructions consumed without producing a command retire in WAIT.
    assign w_retire_local = w_is_nop | w_is_halt | ~w_is_legal;

    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        opcode_d    = opcode_q;
        ub_addr_d   = ub_addr_q;
        acc_addr_d  = acc_addr_q;
        len_d       = len_q;
        halted_d    = halted_q;
        err_d       = err_q;
        retired_d   = retired_q;
        iq_read     = 1'b0;

        case (state_q)
            ST_HALTED: begin
                if (start_i) begin
                    state_d  = ST_FETCH;
                    halted_d = 1'b0;
                end
            end

            ST_FETCH: begin
                if (!iq_empty_i) begin
                    iq_read = 1'b1;
                    state_d = ST_WAIT;
                end
            end

            // Queue data is valid this cycle; iq_empty_i is irrelevant here
            // because the instruction has already been popped.
            ST_WAIT: begin
                opcode_d   = w_dec_opcode;
                ub_addr_d  = w_dec_ub_addr;
                acc_addr_d = w_dec_acc_addr;
                len_d      = w_dec_len;
                if (w_is_issuable) begin
                    state_d     = ST_ISSUE;
                    cmd_valid_d = 1'b1;
                end else if (w_is_halt) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end else begin
                    state_d = ST_FETCH;
                end
                if (!w_is_legal) begin
                    err_d = 1'b1;
                end
                if (w_retire_local) begin
                    retired_d = retired_q + CNT_W'(1);
                end
            end

            ST_ISSUE: begin
                if (cmd_ready_i) begin
                    cmd_valid_d = 1'b0;
                    retired_d   = retired_q + CNT_W'(1);
                    state_d     = ST_FETCH;
`ifdef INSTR_PREFETCH_EN
                    // Overlap the next pop with the handshake to skip FETCH.
                    if (!iq_empty_i) begin
                        iq_read = 1'b1;
                        state_d = ST_WAIT;
                    end
`endif
                end
            end

            default: begin
                state_d = ST_HALTED;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_HALTED;
            cmd_valid_q <= 1'b0;
            opcode_q    <= '0;
            ub_addr_q   <= '0;
            acc_addr_q  <= '0;
            len_q       <= '0;
            halted_q    <= 1'b1;
            err_q       <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            opcode_q    <= opcode_d;
            ub_addr_q   <= ub_addr_d;
            acc_addr_q  <= acc_addr_d;
            len_q       <= len_d;
            halted_q    <= halted_d;
            err_q       <= err_d;
            retired_q   <= retired_d;
        end
    end

    assign iq_read_o      = iq_read;
    assign cmd_valid_o    = cmd_valid_q;
    assign cmd_opcode_o   = opcode_q;
    assign cmd_ub_addr_o  = ub_addr_q;
    assign cmd_acc_addr_o = acc_addr_q;
    assign cmd_len_o      = len_q;
    assign halted_o       = halted_q;
    assign err_o          = err_q;
    assign retired_o      = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_dispatcher.sv
// ============================================================================
//  Module      : tb_instruction_dispatcher
//  Description : Self-checking bench for instruction_dispatcher. A queue
//                model feeds the DUT; an in-order command scoreboard plus
//                counters derived from the instruction stream predict every
//                output each cycle. Directed scenarios pin literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_dispatcher;

    localparam int CW = 4;   // narrow counter so wrap-around is reached quickly
`ifdef INSTR_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic          iq_empty_i = 1'b1;
    logic [31:0]   iq_instr_i = '0;
    logic          iq_read_o;
    logic          cmd_valid_o;
    logic          cmd_ready_i = 1'b0;
    logic [3:0]    cmd_opcode_o;
    logic [11:0]   cmd_ub_addr_o;
    logic [11:0]   cmd_acc_addr_o;
    logic [3:0]    cmd_len_o;
    logic          halted_o;
    logic          err_o;
    logic [CW-1:0] retired_o;

    instruction_dispatcher #(.CNT_W(CW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .iq_empty_i     (iq_empty_i),
        .iq_instr_i     (iq_instr_i),
        .iq_read_o      (iq_read_o),
        .cmd_valid_o    (cmd_valid_o),
        .cmd_ready_i    (cmd_ready_i),
        .cmd_opcode_o   (cmd_opcode_o),
        .cmd_ub_addr_o  (cmd_ub_addr_o),
        .cmd_acc_addr_o (cmd_acc_addr_o),
        .cmd_len_o      (cmd_len_o),
        .halted_o       (halted_o),
        .err_o          (err_o),
        .retired_o      (retired_o)
    );

    always #5 clk = ~clk;

    // Model state
    logic [31:0]   q[$];        // instructions still in the queue
    logic [31:0]   exp_cmd[$];  // commands expected, in order
    logic [31:0]   pend;        // instruction popped last cycle
    bit            pend_v;
    bit            exp_valid, exp_halted, exp_err;
    logic [CW-1:0] exp_ret;

    // Observations of the DUT
    int            n_chk = 0, n_fail = 0;
    int            cyc = 0, rd_cnt = 0, hs_cnt = 0;
    int            last_rd_cyc = 0;
    int            vrise[$];
    bit            prev_valid = 1'b0;
    logic [31:0]   cap_cmd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_valid  = 1'b0;
        exp_halted = 1'b1;
        exp_err    = 1'b0;
        exp_ret    = '0;
        pend_v     = 1'b0;
        exp_cmd.delete();
    endtask

    // Reset asserted asynchronously between clock edges; checks take effect
    // immediately, before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        rst_ni     = 1'b0;
        start_i    = 1'b0;
        iq_empty_i = 1'b1;
        #1;
        chk("rst_halted", halted_o, 1);
        chk("rst_valid", cmd_valid_o, 0);
        chk("rst_read", iq_read_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_retired", retired_o, 0);
        chk("rst_fields", {cmd_opcode_o, cmd_ub_addr_o, cmd_acc_addr_o, cmd_len_o}, 0);
        model_reset();
        prev_valid = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    // One clock cycle: check outputs, drive inputs, predict the coming edge.
    // rdy_mode: 0 ready low, 1 ready high, 2 random.
    task automatic cycle(input int rdy_mode, input int stall_pct, input bit do_start);
        bit exp_rd;
        logic [3:0] op;
        @(negedge clk);
        cyc++;
        chk("retired", retired_o, exp_ret);
        chk("err", err_o, exp_err);
        chk("halted", halted_o, exp_halted);
        chk("cmd_valid", cmd_valid_o, exp_valid);
        if (exp_valid && exp_cmd.size() > 0)
            chk("cmd_fields", {cmd_opcode_o, cmd_ub_addr_o, cmd_acc_addr_o, cmd_len_o}, exp_cmd[0]);
        if (cmd_valid_o && !prev_valid) begin
            vrise.push_back(cyc);
            cap_cmd = {cmd_opcode_o, cmd_ub_addr_o, cmd_acc_addr_o, cmd_len_o};
        end
        prev_valid = cmd_valid_o;

        cmd_ready_i = (rdy_mode == 2) ? ($urandom_range(0, 99) < 60) : rdy_mode[0];
        start_i     = do_start;
        iq_empty_i  = (q.size() == 0) || ($urandom_range(0, 99) < stall_pct);
        iq_instr_i  = pend_v ? pend : $urandom;
        #1;
        exp_rd = !iq_empty_i && !pend_v && !exp_halted && (!exp_valid || (PF && cmd_ready_i));
        chk("iq_read", iq_read_o, exp_rd);
        if (iq_read_o) begin
            rd_cnt++;
            last_rd_cyc = cyc;
        end
        if (cmd_valid_o && cmd_ready_i) hs_cnt++;

        // Effects of the coming clock edge.
        if (exp_valid && cmd_ready_i) begin
            exp_valid = 1'b0;
            void'(exp_cmd.pop_front());
            exp_ret++;
        end
        if (pend_v) begin
            op = pend[31:28];
            if (op >= 4'd1 && op <= 4'd5) begin
                exp_valid = 1'b1;
                exp_cmd.push_back(pend);
            end else begin
                exp_ret++;
                if (op == 4'd15) exp_halted = 1'b1;
                else if (op != 4'd0) exp_err = 1'b1;
            end
        end else if (exp_halted && start_i) begin
            exp_halted = 1'b0;
        end
        pend_v = exp_rd;
        if (exp_rd) pend = q.pop_front();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int r;
        w = $urandom;
        r = $urandom_range(0, 99);
        if (r < 60)      w[31:28] = 4'($urandom_range(1, 5));
        else if (r < 75) w[31:28] = 4'd0;
        else if (r < 88) w[31:28] = 4'($urandom_range(6, 14));
        else             w[31:28] = 4'd15;
        return w;
    endfunction

    initial begin
        int rd0, hs0, budget;
        model_reset();
        q.delete();
        #12;

        // 1: single MATMUL, latency and fields
        do_reset();
        q.push_back(32'h30A0_0B07);
        cycle(1, 0, 1);
        vrise.delete();
        for (int i = 0; i < 8; i++) cycle(1, 0, 0);
        chk("t1_rise_seen", vrise.size(), 1);
        if (vrise.size() > 0) chk("t1_latency", vrise[0] - last_rd_cyc, 2);
        chk("t1_opcode", cap_cmd[31:28], 4'd3);
        chk("t1_ub", cap_cmd[27:16], 12'h0A0);
        chk("t1_acc", cap_cmd[15:4], 12'h0B0);
        chk("t1_len", cap_cmd[3:0], 4'd7);
        chk("t1_retired", retired_o, 1);

        // 2: ready held low in ISSUE
        do_reset();
        q.push_back(32'h1123_4565);
        cycle(0, 0, 1);
        budget = 0;
        while (!cmd_valid_o && budget < 10) begin cycle(0, 0, 0); budget++; end
        chk("t2_reach_issue", cmd_valid_o, 1);
        rd0 = rd_cnt; hs0 = hs_cnt;
        for (int i = 0; i < 5; i++) cycle(0, 0, 0);
        chk("t2_no_read", rd_cnt - rd0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0);
        chk("t2_single_hs", hs_cnt - hs0, 1);

        // 3: NOP, illegal, RD_HOST
        do_reset();
        q.push_back(32'h0000_0000);
        q.push_back(32'h9ABC_DEF0);
        q.push_back(32'h1555_AAA3);
        hs0 = hs_cnt;
        cycle(1, 0, 1);
        for (int i = 0; i < 14; i++) cycle(1, 0, 0);
        chk("t3_err", err_o, 1);
        chk("t3_retired", retired_o, 3);
        chk("t3_issued", hs_cnt - hs0, 1);

        // 4: HALT then MATMUL
        do_reset();
        q.push_back(32'hF000_0000);
        q.push_back(32'h3123_4561);
        rd0 = rd_cnt; hs0 = hs_cnt;
        cycle(1, 0, 1);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0);
        chk("t4_halted", halted_o, 1);
        chk("t4_one_read", rd_cnt - rd0, 1);
        cycle(1, 0, 1);
        for (int i = 0; i < 6; i++) cycle(1, 0, 0);
        chk("t4_issued", hs_cnt - hs0, 1);
        chk("t4_running", halted_o, 0);

        // 5: empty queue in FETCH, then reset during ISSUE
        do_reset();
        rd0 = rd_cnt;
        cycle(1, 0, 1);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0);
        chk("t5_no_read", rd_cnt - rd0, 0);
        q.push_back(32'h4FFF_FFFF);
        budget = 0;
        while (!cmd_valid_o && budget < 10) begin cycle(0, 0, 0); budget++; end
        chk("t5_reach_issue", cmd_valid_o, 1);
        do_reset();

        // 6: four RD_WEIGHT back to back
        do_reset();
        for (int i = 0; i < 4; i++) q.push_back(32'h2000_0000 | (i << 4));
        cycle(1, 0, 1);
        vrise.delete();
        for (int i = 0; i < 16; i++) cycle(1, 0, 0);
        chk("t6_pulses", vrise.size(), 4);
        for (int i = 1; i < vrise.size(); i++)
            chk("t6_gap", vrise[i] - vrise[i-1], PF ? 2 : 3);

        // Random streams with stalls, random ready and random start pulses
        for (int round = 0; round < 4; round++) begin
            do_reset();
            q.delete();
            for (int i = 0; i < 80; i++) q.push_back(rand_instr());
            budget = 0;
            while ((q.size() > 0 || pend_v || exp_valid) && budget < 3000) begin
                cycle(2, 25, exp_halted ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0));
                budget++;
            end
            chk("rand_drained", budget < 3000, 1);
            cycle(2, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
